// File: rtl/alu_pipe_pkg.sv
// Shared opcode encodings and flag bit positions for the alu_pipe block.
package alu_pipe_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU core: {a,b,op} -> {res,flags}.
// Optional multiply on op 111 when ALU_PIPE_MUL_EN is defined.
module alu_pipe_core
  import alu_pipe_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       flags
);

  localparam int MSB = WIDTH - 1;

  logic [SHW-1:0]   w_amt;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_shl;
  logic [WIDTH:0]   w_shr;
  logic             w_slt;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;

  assign w_amt  = b[SHW-1:0];
  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  // One extra bit on each shift catches the last bit shifted out; it stays 0 for amount 0.
  assign w_shl  = {1'b0, a} << w_amt;
  assign w_shr  = {a, 1'b0} >> w_amt;
  assign w_slt  = $signed(a) < $signed(b);

`ifdef ALU_PIPE_MUL_EN
  logic [2*WIDTH-1:0] w_prod;
  assign w_prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (op)
      OP_ADD: begin
        w_res = w_sum[MSB:0];
        w_c   = w_sum[WIDTH];
        w_v   = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        w_res = w_diff[MSB:0];
        w_c   = w_diff[WIDTH];
        w_v   = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
      end
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_XOR: w_res = a ^ b;
      OP_SLT: w_res = {{(WIDTH-1){1'b0}}, w_slt};
      OP_SH: begin
        if (b[MSB]) begin
          w_res = w_shr[WIDTH:1];
          w_c   = w_shr[0];
        end else begin
          w_res = w_shl[MSB:0];
          w_c   = w_shl[WIDTH];
        end
      end
      OP_MUL: begin
`ifdef ALU_PIPE_MUL_EN
        w_res = w_prod[MSB:0];
        w_c   = |w_prod[2*WIDTH-1:WIDTH];
`endif
      end
      default: ;
    endcase
  end

  always_comb begin
    flags        = '0;
    flags[FLG_N] = w_res[MSB];
    flags[FLG_Z] = (w_res == '0);
    flags[FLG_C] = w_c;
    flags[FLG_V] = w_v;
  end

  assign res = w_res;

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready pipelined ALU: stage A holds operands, stage B holds results.
// Build option: define ALU_PIPE_MUL_EN to enable the op 111 multiplier.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       flags,
  output logic             busy
);

  logic             r_va;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic             r_vb;
  logic [WIDTH-1:0] r_res;
  logic [3:0]       r_flags;

  logic             w_adv_b;
  logic             w_accept;
  logic [WIDTH-1:0] w_res;
  logic [3:0]       w_flags;

  // An empty stage always loads, so bubbles collapse under backpressure.
  assign w_adv_b  = ~r_vb | out_ready;
  assign in_ready = ~r_va | w_adv_b;
  assign w_accept = in_valid & in_ready;

  alu_pipe_core #(.WIDTH(WIDTH)) u_core (
    .a     (r_a),
    .b     (r_b),
    .op    (r_op),
    .res   (w_res),
    .flags (w_flags)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_va <= 1'b0;
      r_a  <= '0;
      r_b  <= '0;
      r_op <= '0;
    end else if (in_ready) begin
      r_va <= in_valid;
      if (in_valid) begin
        r_a  <= a;
        r_b  <= b;
        r_op <= op;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vb    <= 1'b0;
      r_res   <= '0;
      r_flags <= '0;
    end else if (w_adv_b) begin
      r_vb <= r_va;
      if (r_va) begin
        r_res   <= w_res;
        r_flags <= w_flags;
      end
    end
  end

  assign out_valid = r_vb;
  assign res       = r_res;
  assign flags     = r_flags;
  assign busy      = r_va | r_vb;

  logic w_unused;
  assign w_unused = w_accept;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (WIDTH=32), expected values computed by hand.
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic [3:0]  flags;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  alu_pipe #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .flags     (flags),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single beat with out_ready=1: accepted at edge k, result visible after edge k+1.
  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb2,
                        input logic [2:0] top, input logic [31:0] er, input logic [3:0] ef);
    a = ta; b = tb2; op = top; in_valid = 1'b1; out_ready = 1'b1;
    check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check({tag, "_early_valid"}, {31'b0, out_valid}, 32'd0);
    tick();
    check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_res"}, res, er);
    check({tag, "_flags"}, {28'b0, flags}, {28'b0, ef});
    tick();
    check({tag, "_drained"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b1;
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_res", res, 32'd0);
    check("rst_flags", {28'b0, flags}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    tick();
    reset = 1'b1;
    tick();

    run_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, 32'h8000_0000, 4'b1001);
    run_op("sub_eq",  32'h0000_0005, 32'h0000_0005, OP_SUB, 32'h0000_0000, 4'b0110);
    run_op("sub_brw", 32'h0000_0000, 32'h0000_0001, OP_SUB, 32'hFFFF_FFFF, 4'b1000);
    run_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, OP_SUB, 32'h7FFF_FFFF, 4'b0011);
    run_op("slt_neg", 32'hFFFF_FFFF, 32'h0000_0001, OP_SLT, 32'h0000_0001, 4'b0000);
    run_op("and",     32'hF0F0_F0F0, 32'hFF00_FF00, OP_AND, 32'hF000_F000, 4'b1000);
    run_op("or",      32'h0000_000F, 32'h0000_00F0, OP_OR,  32'h0000_00FF, 4'b0000);
    run_op("xor_z",   32'h0000_1234, 32'h0000_1234, OP_XOR, 32'h0000_0000, 4'b0100);
    run_op("shl",     32'h8000_0001, 32'h0000_0001, OP_SH,  32'h0000_0002, 4'b0010);
    run_op("shr",     32'h8000_0001, 32'h8000_0001, OP_SH,  32'h4000_0000, 4'b0010);
    run_op("shr_0",   32'h8000_0000, 32'h8000_0000, OP_SH,  32'h8000_0000, 4'b1000);
`ifdef ALU_PIPE_MUL_EN
    run_op("mul",     32'h0001_0000, 32'h0001_0000, OP_MUL, 32'h0000_0000, 4'b0110);
`else
    run_op("mul_off", 32'h0001_0000, 32'h0001_0000, OP_MUL, 32'h0000_0000, 4'b0100);
`endif

    // Backpressure: three ADD beats against a stalled consumer.
    out_ready = 1'b0; op = OP_ADD; in_valid = 1'b1; a = 32'd1; b = 32'd1;
    tick();
    check("bp_ready_1", {31'b0, in_ready}, 32'd1);
    a = 32'd2; b = 32'd2;
    tick();
    check("bp_ready_2", {31'b0, in_ready}, 32'd0);
    check("bp_valid_2", {31'b0, out_valid}, 32'd1);
    check("bp_res_2", res, 32'd2);
    a = 32'd3; b = 32'd3;
    tick();
    check("bp_hold_ready", {31'b0, in_ready}, 32'd0);
    check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
    check("bp_hold_res", res, 32'd2);
    check("bp_hold_flags", {28'b0, flags}, 32'd0);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("bp_out_4", res, 32'd4);
    check("bp_valid_4", {31'b0, out_valid}, 32'd1);
    tick();
    check("bp_out_6", res, 32'd6);
    check("bp_valid_6", {31'b0, out_valid}, 32'd1);
    tick();
    check("bp_empty", {31'b0, out_valid}, 32'd0);
    check("bp_idle", {31'b0, busy}, 32'd0);

    // Reset with both stages full discards everything at once.
    out_ready = 1'b0; in_valid = 1'b1; a = 32'd7; b = 32'd7; op = OP_ADD;
    tick();
    a = 32'd8; b = 32'd8;
    tick();
    in_valid = 1'b0;
    check("mr_full_ready", {31'b0, in_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check("mr_out_valid", {31'b0, out_valid}, 32'd0);
    check("mr_busy", {31'b0, busy}, 32'd0);
    check("mr_in_ready", {31'b0, in_ready}, 32'd1);
    check("mr_res", res, 32'd0);
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    tick();
    check("mr_no_ghost", {31'b0, out_valid}, 32'd0);
    run_op("post_rst", 32'd1, 32'd2, OP_ADD, 32'd3, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, two-stage pipelined successor to the single-cycle 2-bit-op ALU. It has a WIDTH-generic datapath and a 3-bit opcode covering arithmetic, logic, shift and compare. Flags are NZCV. Input and output use valid/ready handshakes with full backpressure. It sits between the operand-fetch and writeback stages, and the vector-file bench drives and checks it.

Parameters:
WIDTH, 32, datapath width in bits (>=8, power of 2).
SHW, $clog2(WIDTH), shift-amount width; derived, not overridable.

Ports:
clk  in  1  single clock, rising-edge.
reset  in  1  asynchronous, active-low reset.
in_valid  in  1  operand/op beat valid.
in_ready  out  1  block accepts a beat this cycle.
a  in  WIDTH  operand A.
b  in  WIDTH  operand B; b[SHW-1:0] is the shift amount for shifts.
op  in  3  opcode (see Behaviour).
out_valid  out  1  result beat valid.
out_ready  in  1  consumer accepts the result this cycle.
res  out  WIDTH  result.
flags  out  4  {N,Z,C,V}: [3]=N, [2]=Z, [1]=C, [0]=V.
busy  out  1  any pipeline stage holds a valid beat.

Behaviour:
- Reset (reset low, async): both stage valids = 0; all stage data = 0. Outputs: in_ready=1, out_valid=0, res=0, flags=0, busy=0. Release is synchronous to clk.
- Stage A registers {a,b,op}. Combinational core sits between A and B. Stage B registers {res,flags}.
- Advance rules:
  - advB = ~vB | out_ready.
  - advA = advB.
  - in_ready = ~vA | advA.
  - Accept when in_valid & in_ready.
  - Bubbles collapse: an empty stage always loads.
- Latency: a beat accepted at edge k shows out_valid=1 after edge k+1, if not stalled.
- Throughput is 1 beat/cycle when out_ready=1. Results stay in order; no drop, no duplicate.
- While out_valid=1 & out_ready=0: res, flags and out_valid hold stable.
- Simultaneous accept and output on the same edge is legal at full rate.
- Opcodes:
  - 000 ADD: res=a+b; C=carry-out; V=signed overflow.
  - 001 SUB: res=a+~b+1; C=carry-out (1 = no borrow); V=signed overflow.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SLT: res=1 if $signed(a)<$signed(b), else 0.
  - 110 SHL/SHR: direction set by b[WIDTH-1] (0=left, 1=logical right); amount b[SHW-1:0]; C=last bit shifted out (0 if amount 0).
  - 111 MUL: see Optional Feature.
- Flag rules: N=res[WIDTH-1] and Z=(res==0) for all ops. C=V=0 for AND/OR/XOR/SLT. V=0 for shifts.
- Mid-operation reset discards all in-flight beats immediately; no output beat follows.
- busy = vA | vB.

Optional Feature:
Macro ALU_PIPE_MUL_EN.
- Defined: op 111 gives res = low WIDTH bits of the unsigned a*b, computed in the A→B stage. C = (upper WIDTH bits != 0); V=0. Latency is unchanged.
- Undefined: op 111 gives res=0, flags=4'b0100. No multiplier is inferred.

Decomposition:
- Package alu_pipe_pkg holds:
  - opcode localparams: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SH, OP_MUL;
  - flag bit indices: FLG_N=3, FLG_Z=2, FLG_C=1, FLG_V=0.
- One sub-module, alu_pipe_core: purely combinational WIDTH-parametrised {a,b,op} -> {res,flags}, including the MUL path under the macro.
- The top, alu_pipe, contains only the two stages and the handshake logic.

Test Plan:
- ADD a=0x7FFFFFFF, b=0x00000001, out_ready=1 -> two cycles later res=0x80000000, flags=4'b1001.
- SUB a=b=0x00000005 -> res=0, flags=4'b0110. SLT a=0xFFFFFFFF, b=1 -> res=1, flags=4'b0000.
- SH a=0x80000001, b=0x00000001 (left) -> res=0x00000002, flags=4'b0010. b=0x80000001 (right) -> res=0x40000000, flags=4'b0010.
- Backpressure: out_ready=0, drive 3 ADD beats (1+1, 2+2, 3+3) -> in_ready drops after 2 accepts and res holds 2. Then out_ready=1 -> outputs 2, 4, 6 in order, one per cycle.
- Reset pulse while vA=vB=1 -> out_valid=0, busy=0, in_ready=1 immediately. After release, a fresh ADD 1+2 -> res=3, flags=0.
- MUL a=b=0x00010000: with ALU_PIPE_MUL_EN -> res=0, flags=4'b0110. Without it -> res=0, flags=4'b0100.
